// File: rtl/imm_encode.sv
// Immediate encoder and li expander: packs a 32-bit immediate into the I/S/B/J/U
// fields of a template instruction, or expands li into ADDI / LUI / LUI+ADDI.
module imm_encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  immsrc,
  input  logic [31:0] tmpl,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  // Handshake: a transfer occurs on a rising edge where valid && ready are both 1;
  // out_instr/out_err/out_last stay stable while out_valid && !out_ready.

  typedef enum logic {IDLE = 1'b0, LI2 = 1'b1} state_t;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  state_t      state, state_next;
  logic [31:0] pend, pend_next;
  logic        valid_next, err_next, last_next;
  logic [31:0] instr_next;

  logic [31:0] enc_instr, li_addi;
  logic        enc_err, li_two;
  logic        fits12, fits13, fits21;
  logic [4:0]  rd;
  logic [11:0] lo;
  logic [19:0] hi;

  assign fits12 = (imm[31:11] == {21{imm[31]}});
  assign fits13 = (imm[31:12] == {20{imm[31]}});
  assign fits21 = (imm[31:20] == {12{imm[31]}});
  assign rd     = tmpl[11:7];
  assign lo     = imm[11:0];
  // Upper part is rounded up when lo will be sign-extended negative by ADDI.
  assign hi     = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    enc_instr = tmpl;
    enc_err   = 1'b0;
    li_two    = 1'b0;
    li_addi   = {lo, rd, 3'b000, rd, OP_ADDI};
    case (immsrc)
      3'b000: begin
        enc_instr = {imm[11:0], tmpl[19:0]};
        enc_err   = !fits12;
      end
      3'b001: begin
        enc_instr = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
        enc_err   = !fits12;
      end
      3'b010: begin
        enc_instr = {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]};
        enc_err   = !fits13 || imm[0];
      end
      3'b011: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
        enc_err   = !fits21 || imm[0];
      end
      3'b100: begin
        enc_instr = {imm[31:12], tmpl[11:0]};
        enc_err   = (imm[11:0] != 12'd0);
      end
      3'b101: begin
        if (fits12) begin
          enc_instr = {lo, 5'd0, 3'b000, rd, OP_ADDI};
        end else if (lo == 12'd0) begin
          enc_instr = {imm[31:12], rd, OP_LUI};
        end else begin
          enc_instr = {hi, rd, OP_LUI};
          li_two    = 1'b1;
        end
      end
      default: begin
        enc_instr = tmpl;
        enc_err   = 1'b1;
      end
    endcase
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  always_comb begin
    state_next = state;
    pend_next  = pend;
    valid_next = out_valid;
    instr_next = out_instr;
    err_next   = out_err;
    last_next  = out_last;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          valid_next = 1'b1;
          instr_next = enc_instr;
          err_next   = enc_err;
          last_next  = !li_two;
          if (li_two) begin
            pend_next  = li_addi;
            state_next = LI2;
          end
        end else if (out_ready) begin
          valid_next = 1'b0;
        end
      end
      LI2: begin
        if (out_valid && out_ready) begin
          valid_next = 1'b1;
          instr_next = pend;
          err_next   = 1'b0;
          last_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= 32'd0;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      pend      <= pend_next;
      out_valid <= valid_next;
      out_instr <= instr_next;
      out_err   <= err_next;
      out_last  <= last_next;
    end
  end

endmodule
